// File: rtl/invaders_rom_loader.sv
// Download sequencer: maps HPS ioctl file offsets onto the game memory download bus
// and holds the CPU in reset until the image is loaded and has settled.
module invaders_rom_loader #(
  parameter logic [7:0]  ROM_INDEX      = 8'd0,
  parameter int unsigned ROM1_SIZE      = 8192,
  parameter int unsigned ROM2_SIZE      = 8192,
  parameter int unsigned PROM_SIZE      = 2048,
  parameter int unsigned WR_HOLD        = 2,
  parameter int unsigned RELEASE_CYCLES = 1024
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        cpu_reset,
  output logic        load_done,
  output logic [16:0] byte_count,
  output logic [15:0] rom_checksum,
  output logic        err_flag
);

  typedef enum logic [1:0] {StIdle, StLoad, StRelease, StRun} state_e;

  localparam int unsigned   RelW     = $clog2(RELEASE_CYCLES + 1);
  localparam logic [24:0]   Rom2Base = 25'(ROM1_SIZE);
  localparam logic [24:0]   PromBase = 25'(ROM1_SIZE + ROM2_SIZE);
  localparam logic [24:0]   PromEnd  = 25'(ROM1_SIZE + ROM2_SIZE + PROM_SIZE);
  localparam logic [3:0]    HoldLast = 4'(WR_HOLD - 1);
  localparam logic [RelW-1:0] RelLast = RelW'(RELEASE_CYCLES - 1);

  state_e          state_q, state_d;
  logic [15:0]     dn_addr_q, dn_addr_d;
  logic [7:0]      dn_data_q, dn_data_d;
  logic            dn_wr_q, dn_wr_d;
  logic [3:0]      hold_cnt_q, hold_cnt_d;
  logic [RelW-1:0] rel_cnt_q, rel_cnt_d;
  logic [16:0]     byte_count_q, byte_count_d;
  logic [15:0]     checksum_q, checksum_d;
  logic            err_q, err_d;

  logic        active;
  logic        in_range;
  logic [15:0] map_addr;
  logic [24:0] offset;

  assign active = ioctl_download && (ioctl_index == ROM_INDEX);

  // Full-width compares so huge offsets never alias into the 16-bit map.
  always_comb begin
    in_range = 1'b1;
    offset   = '0;
    map_addr = '0;
    if (ioctl_addr < Rom2Base) begin
      offset   = ioctl_addr;
      map_addr = offset[15:0];
    end else if (ioctl_addr < PromBase) begin
      offset   = ioctl_addr - Rom2Base;
      map_addr = 16'h2000 + offset[15:0];
    end else if (ioctl_addr < PromEnd) begin
      offset   = ioctl_addr - PromBase;
      map_addr = 16'h4000 + offset[15:0];
    end else begin
      in_range = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    dn_addr_d    = dn_addr_q;
    dn_data_d    = dn_data_q;
    dn_wr_d      = dn_wr_q;
    hold_cnt_d   = hold_cnt_q;
    rel_cnt_d    = rel_cnt_q;
    byte_count_d = byte_count_q;
    checksum_d   = checksum_q;
    err_d        = err_q;

    if (dn_wr_q) begin
      if (hold_cnt_q == HoldLast) begin
        dn_wr_d    = 1'b0;
        hold_cnt_d = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + 4'd1;
      end
    end

    case (state_q)
      StIdle, StRelease, StRun: begin
        if (active) begin
          state_d      = StLoad;
          rel_cnt_d    = '0;
          byte_count_d = '0;
          checksum_d   = '0;
          err_d        = 1'b0;
        end else if (state_q == StRelease) begin
          if (rel_cnt_q == RelLast) state_d = StRun;
          else rel_cnt_d = rel_cnt_q + RelW'(1);
        end
      end
      StLoad: begin
        if (active && ioctl_wr) begin
          if (dn_wr_q || !in_range) begin
            err_d = 1'b1;
          end else begin
            dn_wr_d      = 1'b1;
            hold_cnt_d   = '0;
            dn_addr_d    = map_addr;
            dn_data_d    = ioctl_dout;
            checksum_d   = checksum_q + {8'h00, ioctl_dout};
            if (byte_count_q != 17'h1FFFF) byte_count_d = byte_count_q + 17'd1;
          end
        end
        // The edge that sees the download gone counts as the first settle cycle.
        if (!active && !dn_wr_q) begin
          rel_cnt_d = RelW'(1);
          if (RELEASE_CYCLES > 1) state_d = StRelease;
          else state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= StIdle;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      dn_wr_q      <= 1'b0;
      hold_cnt_q   <= '0;
      rel_cnt_q    <= '0;
      byte_count_q <= '0;
      checksum_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      dn_wr_q      <= dn_wr_d;
      hold_cnt_q   <= hold_cnt_d;
      rel_cnt_q    <= rel_cnt_d;
      byte_count_q <= byte_count_d;
      checksum_q   <= checksum_d;
      err_q        <= err_d;
    end
  end

  assign dn_addr      = dn_addr_q;
  assign dn_data      = dn_data_q;
  assign dn_wr        = dn_wr_q;
  assign ioctl_wait   = dn_wr_q;
  assign cpu_reset    = (state_q != StRun);
  assign load_done    = (state_q == StRun);
  assign byte_count   = byte_count_q;
  assign rom_checksum = checksum_q;
  assign err_flag     = err_q;

endmodule
